// File: rtl/alu_pkg.sv
// Shared types and opcode helpers for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned OpW = 5;

  typedef enum logic [OpW-1:0] {
    AluAdd    = 5'b0_0000,
    AluSll    = 5'b0_0001,
    AluSlt    = 5'b0_0010,
    AluSltu   = 5'b0_0011,
    AluXor    = 5'b0_0100,
    AluSrl    = 5'b0_0101,
    AluOr     = 5'b0_0110,
    AluAnd    = 5'b0_0111,
    AluSub    = 5'b0_1000,
    AluSra    = 5'b0_1101,
    AluMul    = 5'b1_0000,
    AluMulh   = 5'b1_0001,
    AluMulhsu = 5'b1_0010,
    AluMulhu  = 5'b1_0011,
    AluDiv    = 5'b1_0100,
    AluDivu   = 5'b1_0101,
    AluRem    = 5'b1_0110,
    AluRemu   = 5'b1_0111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_e;

  function automatic logic is_muldiv(alu_op_e op);
    return op[4];
  endfunction

  function automatic logic is_legal(alu_op_e op);
    logic ok;
    case (op)
      AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd, AluSub, AluSra,
      AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle, XLEN cycles per op.
// Works on operand magnitudes; the sign is applied to the final result combinationally.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            kill_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            active_q, is_div_q, sel_hi_q, neg_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, den_q;

  logic            start_div, a_sg, b_sg, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_rs, div_diff;
  logic [XLEN-1:0] hi_n, lo_n, quot_rem;
  logic [2*XLEN-1:0] prod, prod_s;

  assign start_div = op_i[2];

  always_comb begin
    if (start_div) begin
      a_sg = !op_i[0];
      b_sg = !op_i[0];
    end else begin
      // MULH and MULHSU treat A as signed; only MULH treats B as signed.
      a_sg = op_i[1] ^ op_i[0];
      b_sg = (op_i[1:0] == 2'b01);
    end
  end

  assign a_neg = a_sg & a_i[XLEN-1];
  assign b_neg = b_sg & b_i[XLEN-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // hi holds product-high / partial remainder; lo holds multiplier / dividend-then-quotient.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : {(XLEN+1){1'b0}});
    div_rs   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_rs - {1'b0, den_q};
    if (is_div_q) begin
      if (!div_diff[XLEN]) begin
        hi_n = div_diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = div_rs[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod     = {hi_n, lo_n};
    prod_s   = neg_q ? -prod : prod;
    quot_rem = sel_hi_q ? hi_n : lo_n;
    if (is_div_q) begin
      result_o = neg_q ? -quot_rem : quot_rem;
    end else begin
      result_o = sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  assign done_o = active_q && (cnt_q == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || kill_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(XLEN - 1);
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (start_i) begin
      is_div_q <= start_div;
      sel_hi_q <= start_div ? op_i[1] : (op_i[1:0] != 2'b00);
      // Remainder follows the dividend; quotient and product follow the sign product.
      neg_q    <= (start_div && op_i[1]) ? a_neg : (a_neg ^ b_neg);
      hi_q     <= '0;
      lo_q     <= start_div ? a_mag : b_mag;
      den_q    <= start_div ? b_mag : a_mag;
    end else if (active_q) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with valid/ready handshakes; base ops complete in one cycle.
// M-extension ops run on alu_muldiv_iter only when ALU_MC_MULDIV_EN is defined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [OpW-1:0]  alu_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] alu_data_o,
  output logic            illegal_o,
  output logic            busy_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e      state_q;
  logic [XLEN-1:0] data_q;
  logic            illegal_q;

  alu_op_e         op;
  logic            legal, in_ready, accept, iter_start, iter_done;
  logic [XLEN-1:0] base_res, fast_res, iter_res, special_res, int_min;
  logic [SHW-1:0]  shamt;
  logic            div_op, div_signed, div_rem, b_zero, div_ovf, div_special;

  assign op      = alu_op_e'(alu_op_i);
  assign shamt   = operand_b_i[SHW-1:0];
  assign int_min = {1'b1, {(XLEN-1){1'b0}}};

`ifdef ALU_MC_MULDIV_EN
  assign legal = is_legal(op);
`else
  assign legal = is_legal(op) && !is_muldiv(op);
`endif

  assign in_ready = !flush_i && ((state_q == IDLE) || ((state_q == DONE) && out_ready_i));
  assign accept   = in_valid_i && in_ready;

  always_comb begin
    base_res = '0;
    case (op)
      AluAdd:  base_res = operand_a_i + operand_b_i;
      AluSub:  base_res = operand_a_i - operand_b_i;
      AluSlt:  base_res = {{(XLEN-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
      AluSltu: base_res = {{(XLEN-1){1'b0}}, operand_a_i < operand_b_i};
      AluXor:  base_res = operand_a_i ^ operand_b_i;
      AluOr:   base_res = operand_a_i | operand_b_i;
      AluAnd:  base_res = operand_a_i & operand_b_i;
      AluSll:  base_res = operand_a_i << shamt;
      AluSrl:  base_res = operand_a_i >> shamt;
      AluSra:  base_res = $unsigned($signed(operand_a_i) >>> shamt);
      default: base_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow resolve in one cycle without iterating.
  assign div_op      = alu_op_i[4] && (alu_op_i[3:2] == 2'b01);
  assign div_signed  = !alu_op_i[0];
  assign div_rem     = alu_op_i[1];
  assign b_zero      = (operand_b_i == '0);
  assign div_ovf     = div_signed && (operand_a_i == int_min) && (operand_b_i == '1);
  assign div_special = div_op && (b_zero || div_ovf);

  always_comb begin
    if (b_zero) begin
      special_res = div_rem ? operand_a_i : '1;
    end else begin
      special_res = div_rem ? '0 : operand_a_i;
    end
  end

  always_comb begin
    if (!legal) begin
      fast_res = '0;
    end else if (div_special) begin
      fast_res = special_res;
    end else begin
      fast_res = base_res;
    end
  end

`ifdef ALU_MC_MULDIV_EN
  assign iter_start = accept && legal && is_muldiv(op) && !div_special;

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .kill_i  (flush_i),
    .start_i (iter_start),
    .op_i    (alu_op_i[2:0]),
    .a_i     (operand_a_i),
    .b_i     (operand_b_i),
    .done_o  (iter_done),
    .result_o(iter_res)
  );

  assign busy_o = (state_q == BUSY);
`else
  assign iter_start = 1'b0;
  assign iter_done  = 1'b0;
  assign iter_res   = '0;
  assign busy_o     = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      state_q   <= IDLE;
      data_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            if (iter_start) begin
              state_q <= BUSY;
            end else begin
              state_q   <= DONE;
              data_q    <= fast_res;
              illegal_q <= !legal;
            end
          end else if ((state_q == DONE) && out_ready_i) begin
            state_q <= IDLE;
          end
        end
        BUSY: begin
          if (iter_done) begin
            state_q   <= DONE;
            data_q    <= iter_res;
            illegal_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = (state_q == DONE);
  assign alu_data_o  = data_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a monitor pops on handshake.
module tb_alu_mc;
  import alu_pkg::*;

`ifdef ALU_MC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [4:0]  alu_op;
  logic [31:0] opa, opb;
  logic        in_ready_o, out_valid_o, illegal_o, busy_o;
  logic [31:0] alu_data_o;

  typedef struct {
    logic [31:0] data;
    logic        ill;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_seen = 0;
  int   last_wait = 0;

  alu_mc #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .alu_op_i   (alu_op),
    .operand_a_i(opa),
    .operand_b_i(opb),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready),
    .alu_data_o (alu_data_o),
    .illegal_o  (illegal_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input string nm, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ed, input logic ei,
                       input int lat, input bit push);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    alu_op   = op;
    opa      = a;
    opb      = b;
    last_wait = 0;
    @(negedge clk);
    while (!in_ready_o && last_wait < 200) begin
      last_wait++;
      @(negedge clk);
    end
    if (!in_ready_o) begin
      total++;
      bad++;
      $display("FAIL accept_timeout %s: in_ready got 0 expected 1", nm);
    end else if (push) begin
      e.data = ed;
      e.ill  = ei;
      e.lat  = lat;
      e.acc  = cyc;
      e.nm   = nm;
      sb.push_back(e);
    end
  endtask

  // M ops: real result when the unit is built, otherwise a 1-cycle illegal response.
  task automatic mop(input string nm, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] val, input bit iter);
    issue(nm, op, a, b, MD ? val : 32'h0, !MD, (MD && iter) ? 33 : 1, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending got %0d expected 0", sb.size());
    end
  endtask

  // Monitor: every valid cycle is compared against the head; popped on handshake.
  initial begin
    bit first_seen;
    first_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_o) busy_seen++;
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: data got %h expected no result", alu_data_o);
        end else begin
          if (!first_seen) begin
            first_seen = 1'b1;
            check({"latency ", sb[0].nm}, cyc - sb[0].acc, sb[0].lat);
          end
          check({"data ", sb[0].nm}, alu_data_o, sb[0].data);
          check({"illegal ", sb[0].nm}, {31'h0, illegal_o}, {31'h0, sb[0].ill});
          if (out_ready) begin
            void'(sb.pop_front());
            first_seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time got %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst out_valid", out_valid_o, 0);
    check("rst data", alu_data_o, 0);
    check("rst illegal", illegal_o, 0);
    check("rst busy", busy_o, 0);
    check("rst in_ready", in_ready_o, 1);

    // Base ops and illegal codes.
    issue("add_wrap", AluAdd, 32'h7fffffff, 32'h1, 32'h80000000, 0, 1, 1);
    issue("sra", AluSra, 32'h80000000, 32'h24, 32'hf8000000, 0, 1, 1);
    issue("slt", AluSlt, 32'hffffffff, 32'h1, 32'h1, 0, 1, 1);
    issue("slt_neg", AluSlt, 32'h1, 32'hffffffff, 32'h0, 0, 1, 1);
    issue("sll", AluSll, 32'h1, 32'h3f, 32'h80000000, 0, 1, 1);
    issue("srl", AluSrl, 32'h80000000, 32'h21, 32'h40000000, 0, 1, 1);
    issue("xor", AluXor, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 0, 1, 1);
    issue("or", AluOr, 32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 0, 1, 1);
    issue("and", AluAnd, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 0, 1, 1);
    issue("illegal_0f", 5'h0f, 32'h5, 32'h6, 32'h0, 1, 1, 1);
    issue("illegal_18", 5'h18, 32'h5, 32'h6, 32'h0, 1, 1, 1);
    idle();
    drain();

    // Back-to-back accept while the previous result is consumed.
    issue("sub", AluSub, 32'd5, 32'd7, 32'hfffffffe, 0, 1, 1);
    issue("sltu", AluSltu, 32'd1, 32'hffffffff, 32'h1, 0, 1, 1);
    check("b2b in_ready wait", last_wait, 0);
    idle();
    drain();

    // Iterative divide with busy tracking.
    mop("div", AluDiv, 32'hffffffec, 32'd3, 32'hfffffffa, 1);
    idle();
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (busy_o) n++;
      if (out_valid_o) break;
    end
    check("div busy cycles", n, MD ? 32 : 0);
    drain();
    mop("rem", AluRem, 32'hffffffec, 32'd3, 32'hfffffffe, 1);
    mop("div_negb", AluDiv, 32'd20, 32'hfffffffd, 32'hfffffffa, 1);
    mop("rem_negb", AluRem, 32'd20, 32'hfffffffd, 32'h2, 1);
    mop("divu", AluDivu, 32'd100, 32'd7, 32'd14, 1);
    mop("remu", AluRemu, 32'd100, 32'd7, 32'd2, 1);
    idle();
    drain();

    // Division special cases and multiplies.
    mop("divu_by0", AluDivu, 32'd7, 32'h0, 32'hffffffff, 0);
    mop("rem_by0", AluRem, 32'd5, 32'h0, 32'd5, 0);
    mop("div_ovf", AluDiv, 32'h80000000, 32'hffffffff, 32'h80000000, 0);
    mop("rem_ovf", AluRem, 32'h80000000, 32'hffffffff, 32'h0, 0);
    mop("mulhu", AluMulhu, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 1);
    mop("mul_low", AluMul, 32'hffffffff, 32'hffffffff, 32'h1, 1);
    mop("mulh", AluMulh, 32'hffffffff, 32'hffffffff, 32'h0, 1);
    mop("mulhsu", AluMulhsu, 32'hffffffff, 32'hffffffff, 32'hffffffff, 1);
    mop("mulh_neg", AluMulh, 32'hfffffffe, 32'd3, 32'hffffffff, 1);
    mop("mul", AluMul, 32'd3, 32'd4, 32'd12, 1);
    idle();
    drain();

`ifdef ALU_MC_MULDIV_EN
    // Reset while iterating: no result, everything back to reset values.
    issue("div_reset", AluDiv, 32'd100, 32'd7, 32'h0, 0, 0, 0);
    idle();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("busy before reset", busy_o, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", busy_o, 0);
    check("reset out_valid", out_valid_o, 0);
    check("reset data", alu_data_o, 0);
    check("reset illegal", illegal_o, 0);
    check("reset in_ready", in_ready_o, 1);
    repeat (40) @(negedge clk);
`endif

    // Backpressure: result held, no new accept.
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue("bp_add", AluAdd, 32'd100, 32'd23, 32'd123, 0, 1, 1);
    idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp in_ready", in_ready_o, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // A request in the flush cycle is refused.
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; alu_op = AluAdd; opa = 32'd1; opb = 32'd1;
    @(negedge clk);
    check("flush in_ready", in_ready_o, 0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush no_valid", out_valid_o, 0);

`ifdef ALU_MC_MULDIV_EN
    // Flush mid-multiply drops the op.
    issue("mul_flushed", AluMul, 32'd3, 32'd4, 32'h0, 0, 0, 0);
    idle();
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("busy before flush", busy_o, 1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy", busy_o, 0);
    check("flush idle in_ready", in_ready_o, 1);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid_o) n++;
      @(negedge clk);
    end
    check("flush no result", n, 0);
`else
    check("busy never", busy_seen, 0);
`endif

    drain();
    check("scoreboard empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
